note_lane_engine: RTL

Parametrised multi-lane falling-note engine for the piano game. It replaces the single-block, single-lane height generator with up to SLOTS concurrent blocks in each of LANES lanes. Fall speed is selected by level, and each block retires on a player hit or when it reaches the bottom. It sits between the beat counter and the VGA block renderer and also feeds the scoring logic through hit and miss pulses.

---
 rtl/note_lane_engine_pkg.sv | 14 +
 rtl/note_lane_engine_if.sv | 31 +++
 rtl/note_lane.sv | 132 +++++++++++++
 rtl/note_lane_engine.sv | 100 ++++++++++
 4 files changed

// File: rtl/note_lane_engine_pkg.sv
// Shared defaults and helpers for the falling-note engine.
package note_pkg;

  localparam int unsigned H_W      = 10;
  localparam int unsigned H_TOP    = 120;
  localparam int unsigned H_BOTTOM = 720;
  localparam int unsigned HIT_LO   = 600;

  // Level 0..3 maps to a fall step of 1..4 pixels per tick.
  function automatic logic [2:0] lvl_step(input logic [1:0] level);
    return 3'(level) + 3'd1;
  endfunction

endpackage

// File: rtl/note_lane_engine_if.sv
// Control/status bundle between the game logic and note_lane_engine.
interface note_lane_engine_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned SLOTS = 4,
  parameter int unsigned H_W   = note_pkg::H_W
);

  logic                         stop_or_endgame;
  logic                         tick;
  logic [1:0]                   level;
  logic [6:0]                   beat_cnt;
  logic [LANES-1:0]             spawn_mask;
  logic [LANES-1:0]             hit_req;
  logic [LANES*SLOTS*H_W-1:0]   block_h;
  logic [LANES*SLOTS-1:0]       block_vld;
  logic [LANES-1:0]             hit_ok;
  logic [LANES-1:0]             hit_bad;
  logic [LANES-1:0]             miss;
  logic                         overflow;

  modport master (
    output stop_or_endgame, tick, level, beat_cnt, spawn_mask, hit_req,
    input  block_h, block_vld, hit_ok, hit_bad, miss, overflow
  );

  modport slave (
    input  stop_or_endgame, tick, level, beat_cnt, spawn_mask, hit_req,
    output block_h, block_vld, hit_ok, hit_bad, miss, overflow
  );

endinterface

// File: rtl/note_lane.sv
// One lane's slot pool: spawn into the lowest free slot, fall, retire on hit or at the bottom.
module note_lane
  import note_pkg::*;
#(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned H_W      = note_pkg::H_W,
  parameter int unsigned H_TOP    = note_pkg::H_TOP,
  parameter int unsigned H_BOTTOM = note_pkg::H_BOTTOM,
  parameter int unsigned HIT_LO   = note_pkg::HIT_LO
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 spawn_en,
  input  logic                 move_en,
  input  logic [2:0]           step,
  input  logic                 hit_en,
  output logic [SLOTS*H_W-1:0] h,
  output logic [SLOTS-1:0]     vld,
  output logic                 hit_ok,
  output logic                 hit_bad,
  output logic                 miss,
  output logic                 drop
);

  localparam logic [H_W-1:0] TopH   = H_W'(H_TOP);
  localparam logic [H_W-1:0] BotH   = H_W'(H_BOTTOM);
  localparam logic [H_W:0]   BotSum = (H_W+1)'(H_BOTTOM);
  localparam logic [H_W-1:0] HitLoH = H_W'(HIT_LO);

  logic [H_W-1:0] h_q [SLOTS];
  logic [H_W-1:0] h_d [SLOTS];
  logic [SLOTS-1:0] vld_q, vld_d;
  logic hit_ok_q, hit_ok_d;
  logic hit_bad_q, hit_bad_d;
  logic miss_q, miss_d;

  logic             tgt_found;
  logic [H_W-1:0]   tgt_h;
  logic [SLOTS-1:0] tgt_oh;
  logic             free_found;
  logic [SLOTS-1:0] spawn_oh;
  logic [H_W:0]     sum;

  // Hit target: highest block in the window; strict '>' keeps the lowest index on ties.
  always_comb begin
    tgt_found = 1'b0;
    tgt_h     = '0;
    tgt_oh    = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (vld_q[s] && h_q[s] >= HitLoH && (!tgt_found || h_q[s] > tgt_h)) begin
        tgt_found = 1'b1;
        tgt_h     = h_q[s];
        tgt_oh    = '0;
        tgt_oh[s] = 1'b1;
      end
    end
  end

  // Only slots empty at the start of the cycle are spawnable.
  always_comb begin
    free_found = 1'b0;
    spawn_oh   = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (!vld_q[s] && !free_found) begin
        free_found  = 1'b1;
        spawn_oh[s] = 1'b1;
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    miss_d = 1'b0;
    sum    = '0;
    for (int s = 0; s < SLOTS; s++) begin
      h_d[s] = h_q[s];
      if (vld_q[s]) begin
        if (hit_en && tgt_oh[s]) begin
          vld_d[s] = 1'b0;
        end else if (move_en) begin
          sum = {1'b0, h_q[s]} + (H_W+1)'(step);
          if (sum >= BotSum) begin
            vld_d[s] = 1'b0;
            h_d[s]   = BotH;
            miss_d   = 1'b1;
          end else begin
            h_d[s] = sum[H_W-1:0];
          end
        end
      end else if (spawn_en && spawn_oh[s]) begin
        vld_d[s] = 1'b1;
        h_d[s]   = TopH;
      end
    end
    hit_ok_d  = hit_en && tgt_found;
    hit_bad_d = hit_en && !tgt_found;
    drop      = spawn_en && !free_found;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q     <= '0;
      hit_ok_q  <= 1'b0;
      hit_bad_q <= 1'b0;
      miss_q    <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        h_q[s] <= TopH;
      end
    end else begin
      vld_q     <= vld_d;
      hit_ok_q  <= hit_ok_d;
      hit_bad_q <= hit_bad_d;
      miss_q    <= miss_d;
      for (int s = 0; s < SLOTS; s++) begin
        h_q[s] <= h_d[s];
      end
    end
  end

  always_comb begin
    h = '0;
    for (int s = 0; s < SLOTS; s++) begin
      h[s*H_W +: H_W] = h_q[s];
    end
  end

  assign vld     = vld_q;
  assign hit_ok  = hit_ok_q;
  assign hit_bad = hit_bad_q;
  assign miss    = miss_q;

endmodule

// File: rtl/note_lane_engine.sv
// Multi-lane falling-note engine: beat-edge spawn, level-based fall, hit/miss pulses.
// Optional NOTE_HIT_EN enables player hits; without it blocks retire only at the bottom.
module note_lane_engine
  import note_pkg::*;
#(
  parameter int unsigned LANES    = 4,
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned H_W      = note_pkg::H_W,
  parameter int unsigned H_TOP    = note_pkg::H_TOP,
  parameter int unsigned H_BOTTOM = note_pkg::H_BOTTOM,
  parameter int unsigned HIT_LO   = note_pkg::HIT_LO
) (
  input logic               clk,
  input logic               rst,
  input logic               restart,
  note_lane_engine_if.slave bus
);

  logic             clr;
  logic [6:0]       prev_beat_q;
  logic             beat_edge;
  logic             move_en;
  logic [2:0]       step;
  logic [LANES-1:0] spawn_en;
  logic [LANES-1:0] hit_en;
  logic [LANES-1:0] drop;
  logic [LANES-1:0] lane_ok;
  logic [LANES-1:0] lane_bad;
  logic [LANES-1:0] lane_miss;
  logic             overflow_q;

  logic [SLOTS*H_W-1:0] lane_h   [LANES];
  logic [SLOTS-1:0]     lane_vld [LANES];

  assign clr = rst || restart;

  // A decreasing beat count (song loop) is deliberately not an edge.
  assign beat_edge = bus.beat_cnt > prev_beat_q;
  assign move_en   = bus.tick && !bus.stop_or_endgame;
  assign step      = lvl_step(bus.level);
  assign spawn_en  = bus.spawn_mask & {LANES{beat_edge && !bus.stop_or_endgame}};

`ifdef NOTE_HIT_EN
  assign hit_en      = bus.hit_req & {LANES{!bus.stop_or_endgame}};
  assign bus.hit_ok  = lane_ok;
  assign bus.hit_bad = lane_bad;
`else
  logic unused_hit;
  assign hit_en      = '0;
  assign bus.hit_ok  = '0;
  assign bus.hit_bad = '0;
  assign unused_hit  = ^{bus.hit_req, lane_ok, lane_bad};
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      prev_beat_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      prev_beat_q <= bus.beat_cnt;
      overflow_q  <= overflow_q || (|drop);
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    note_lane #(
      .SLOTS    (SLOTS),
      .H_W      (H_W),
      .H_TOP    (H_TOP),
      .H_BOTTOM (H_BOTTOM),
      .HIT_LO   (HIT_LO)
    ) u_lane (
      .clk      (clk),
      .clr      (clr),
      .spawn_en (spawn_en[l]),
      .move_en  (move_en),
      .step     (step),
      .hit_en   (hit_en[l]),
      .h        (lane_h[l]),
      .vld      (lane_vld[l]),
      .hit_ok   (lane_ok[l]),
      .hit_bad  (lane_bad[l]),
      .miss     (lane_miss[l]),
      .drop     (drop[l])
    );
  end

  always_comb begin
    bus.block_h   = '0;
    bus.block_vld = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.block_h[l*SLOTS*H_W +: SLOTS*H_W] = lane_h[l];
      bus.block_vld[l*SLOTS +: SLOTS]       = lane_vld[l];
    end
  end

  assign bus.miss     = lane_miss;
  assign bus.overflow = overflow_q;

endmodule
